// File: rtl/perf_window_ctrl.sv
// Purpose : measurement-window controller; counts blocks and cycles in an armed window, freezes results.
// Latency : done rises on the edge after the terminating RUN cycle; all outputs registered.
// Backpres: results held in DONE until result_ack (or abort); start only accepted in IDLE.
//
// Ports:
//   clk_i, rst_n_i            clock, synchronous active-low reset
//   start_i / abort_i         arm a window (IDLE only) / discard window (RUN, DONE)
//   cfg_block_target_i        blocks that end the window, 0 = no block limit
//   cfg_cycle_limit_i         RUN cycles that end the window, 0 = no timeout
//   block_completed_i         one-cycle pulse per block leaving the pipeline
//   busy_o, done_o            in RUN / in DONE (results valid)
//   timed_out_o               window ended by the cycle limit
//   result_blocks_o/_cycles_o frozen window result
//   live_blocks_o/_cycles_o   running in-window counts
//   result_ack_i              consumer has read results
module perf_window_ctrl #(
    parameter int unsigned COUNTER_WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic [COUNTER_WIDTH-1:0] cfg_block_target_i,
    input  logic [COUNTER_WIDTH-1:0] cfg_cycle_limit_i,
    input  logic                     block_completed_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     timed_out_o,
    output logic [COUNTER_WIDTH-1:0] result_blocks_o,
    output logic [COUNTER_WIDTH-1:0] result_cycles_o,
    output logic [COUNTER_WIDTH-1:0] live_blocks_o,
    output logic [COUNTER_WIDTH-1:0] live_cycles_o,
    input  logic                     result_ack_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

    state_t                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] tgt_q, tgt_d;
    logic [COUNTER_WIDTH-1:0] lim_q, lim_d;
    logic [COUNTER_WIDTH-1:0] live_blk_q, live_blk_d;
    logic [COUNTER_WIDTH-1:0] live_cyc_q, live_cyc_d;
    logic [COUNTER_WIDTH-1:0] res_blk_q, res_blk_d;
    logic [COUNTER_WIDTH-1:0] res_cyc_q, res_cyc_d;
    logic                     timed_out_q, timed_out_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    // Saturating next-counts for the current RUN cycle.
    logic [COUNTER_WIDTH-1:0] cyc_n, blk_n;
    logic                     blk_end, tim_end;

    always_comb begin
        cyc_n   = (live_cyc_q == CNT_MAX) ? live_cyc_q : live_cyc_q + CNT_ONE;
        blk_n   = (block_completed_i && (live_blk_q != CNT_MAX)) ? live_blk_q + CNT_ONE : live_blk_q;
        blk_end = (tgt_q != '0) && (blk_n >= tgt_q);
        tim_end = (lim_q != '0) && (cyc_n >= lim_q);
    end

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        lim_d       = lim_q;
        live_blk_d  = live_blk_q;
        live_cyc_d  = live_cyc_q;
        res_blk_d   = res_blk_q;
        res_cyc_d   = res_cyc_q;
        timed_out_d = timed_out_q;

        case (state_q)
            S_IDLE: begin
                // Pulse in the start cycle is deliberately not counted.
                if (start_i) begin
                    state_d     = S_RUN;
                    tgt_d       = cfg_block_target_i;
                    lim_d       = cfg_cycle_limit_i;
                    live_blk_d  = '0;
                    live_cyc_d  = '0;
                    res_blk_d   = '0;
                    res_cyc_d   = '0;
                    timed_out_d = 1'b0;
                end
            end
            S_RUN: begin
                // abort outranks both end conditions; results stay cleared.
                if (abort_i) begin
                    state_d = S_IDLE;
                end else begin
                    live_blk_d = blk_n;
                    live_cyc_d = cyc_n;
                    // Block end is checked first so it wins a same-cycle tie.
                    if (blk_end) begin
                        state_d     = S_DONE;
                        res_blk_d   = blk_n;
                        res_cyc_d   = cyc_n;
                        timed_out_d = 1'b0;
                    end else if (tim_end) begin
                        state_d     = S_DONE;
                        res_blk_d   = blk_n;
                        res_cyc_d   = cyc_n;
                        timed_out_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (result_ack_i || abort_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            tgt_q       <= '0;
            lim_q       <= '0;
            live_blk_q  <= '0;
            live_cyc_q  <= '0;
            res_blk_q   <= '0;
            res_cyc_q   <= '0;
            timed_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            lim_q       <= lim_d;
            live_blk_q  <= live_blk_d;
            live_cyc_q  <= live_cyc_d;
            res_blk_q   <= res_blk_d;
            res_cyc_q   <= res_cyc_d;
            timed_out_q <= timed_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign timed_out_o     = timed_out_q;
    assign result_blocks_o = res_blk_q;
    assign result_cycles_o = res_cyc_q;
    assign live_blocks_o   = live_blk_q;
    assign live_cycles_o   = live_cyc_q;

endmodule

// File: tb/tb_perf_window_ctrl.sv
// Purpose : scoreboard bench for perf_window_ctrl (32-bit main instance, 4-bit saturation instance).
// Latency : expected results queued at stimulus time, popped by the monitor on each done rising edge.
// Backpres: result_ack timing randomised; stimulus waits on done with a bounded cycle budget.
module tb_perf_window_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start, abort, bc, ack;
    logic [31:0] cfg_tgt, cfg_lim;
    logic        busy, done, tout;
    logic [31:0] res_blk, res_cyc, live_blk, live_cyc;

    logic        s_start, s_abort, s_bc, s_ack;
    logic [3:0]  s_tgt, s_lim;
    logic        s_busy, s_done, s_tout;
    logic [3:0]  s_rb, s_rc, s_lb, s_lc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int blocks;
        int cycles;
        bit to;
    } exp_t;
    exp_t q[$];

    perf_window_ctrl #(.COUNTER_WIDTH(32)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort),
        .cfg_block_target_i(cfg_tgt), .cfg_cycle_limit_i(cfg_lim),
        .block_completed_i(bc), .busy_o(busy), .done_o(done), .timed_out_o(tout),
        .result_blocks_o(res_blk), .result_cycles_o(res_cyc),
        .live_blocks_o(live_blk), .live_cycles_o(live_cyc), .result_ack_i(ack)
    );

    perf_window_ctrl #(.COUNTER_WIDTH(4)) dut4 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(s_start), .abort_i(s_abort),
        .cfg_block_target_i(s_tgt), .cfg_cycle_limit_i(s_lim),
        .block_completed_i(s_bc), .busy_o(s_busy), .done_o(s_done), .timed_out_o(s_tout),
        .result_blocks_o(s_rb), .result_cycles_o(s_rc),
        .live_blocks_o(s_lb), .live_cycles_o(s_lc), .result_ack_i(s_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: walk the RUN cycles k=1.. applying the window rules directly.
    function automatic void model(input logic [31:0] tgt, input logic [31:0] lim,
                                  input logic [63:0] p, output bit found,
                                  output int blocks, output int kend, output bit to);
        blocks = 0; found = 0; kend = 0; to = 0;
        for (int k = 1; k < 64 && !found; k++) begin
            if (p[k]) blocks++;
            if (tgt != 0 && 32'(blocks) >= tgt) begin
                found = 1; kend = k; to = 0;
            end else if (lim != 0 && 32'(k) >= lim) begin
                found = 1; kend = k; to = 1;
            end
        end
    endfunction

    // Monitor: pops an expectation on every done rising edge, checks hold while done stays high.
    initial begin : monitor
        bit   dp;
        bit   bp;
        int   bcnt;
        exp_t cur;
        dp = 0; bp = 0; bcnt = 0;
        cur.blocks = 0; cur.cycles = 0; cur.to = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                dp = 0; bp = 0; bcnt = 0;
            end else begin
                if (busy) bcnt = bp ? bcnt + 1 : 1;
                if (done && !dp) begin
                    if (q.size() == 0) begin
                        chk("unexpected_done", 128'(done), 128'(0));
                    end else begin
                        cur = q.pop_front();
                        chk("result_blocks", 128'(res_blk), 128'(cur.blocks));
                        chk("result_cycles", 128'(res_cyc), 128'(cur.cycles));
                        chk("timed_out", 128'(tout), 128'(cur.to));
                        chk("live_frozen", 128'({live_blk, live_cyc}), 128'({cur.blocks, cur.cycles}));
                        chk("busy_cycles", 128'(bcnt), 128'(cur.cycles));
                    end
                end else if (done) begin
                    chk("done_hold", 128'({res_blk, res_cyc, tout}), 128'({cur.blocks, cur.cycles, cur.to}));
                end
                dp = done; bp = busy;
            end
        end
    end

    task automatic run_window(input logic [31:0] tgt, input logic [31:0] lim, input logic [63:0] p,
                              input bit abt_in, input int abt_k_in, input int hold, input bit start_with_ack);
        bit   found, to, abt;
        int   blocks, kend, last, abt_k, w;
        exp_t e;
        abt = abt_in; abt_k = abt_k_in;
        model(tgt, lim, p, found, blocks, kend, to);
        if (!found && !abt) begin abt = 1; abt_k = 60; end
        if (abt && found && abt_k > kend) abt = 0;
        e.blocks = blocks; e.cycles = kend; e.to = to;
        if (!abt) q.push_back(e);
        last = abt ? abt_k : kend;

        start = 1; cfg_tgt = tgt; cfg_lim = lim; bc = p[0];
        tick();
        chk("start_accept", 128'({busy, done, tout, res_blk, res_cyc}), 128'({1'b1, 1'b0, 1'b0, 64'd0}));
        start = 0; cfg_tgt = $urandom; cfg_lim = $urandom;
        for (int k = 1; k <= last; k++) begin
            bc    = p[k];
            abort = abt && (k == abt_k);
            start = ($urandom_range(0, 3) == 0);
            tick();
        end
        bc = 0; abort = 0; start = 0;
        if (abt) begin
            chk("abort_idle", 128'({busy, done, res_blk, res_cyc}), 128'(0));
            return;
        end
        chk("done_latency", 128'(done), 128'(1));
        w = 0;
        while (!done && w < 200) begin tick(); w++; end
        if (!done) begin
            chk("done_timeout", 128'(done), 128'(1));
            if (q.size() > 0) void'(q.pop_back());
            abort = 1; tick(); abort = 0;
            return;
        end
        for (int i = 0; i < hold; i++) begin
            bc = 1'($urandom); start = 1'($urandom);
            tick();
        end
        bc = 0; start = 0;
        ack = 1; start = start_with_ack;
        tick();
        ack = 0; start = 0;
        chk("ack_idle", 128'({busy, done}), 128'(0));
        chk("idle_hold", 128'({res_blk, res_cyc, tout}), 128'({e.blocks, e.cycles, e.to}));
    endtask

    initial begin : stim
        logic [63:0] p;
        logic [31:0] tgt, lim;
        int          ak;
        rst_n = 0; start = 0; abort = 0; bc = 0; ack = 0; cfg_tgt = 0; cfg_lim = 0;
        s_start = 0; s_abort = 0; s_bc = 0; s_ack = 0; s_tgt = 0; s_lim = 0;
        repeat (3) tick();
        chk("reset_state", 128'({busy, done, tout, res_blk, res_cyc, live_blk, live_cyc}), 128'(0));
        rst_n = 1;
        tick();
        chk("idle_after_reset", 128'({busy, done, tout, res_blk, res_cyc, live_blk, live_cyc}), 128'(0));

        // Block-terminated: pulses at k=2,5,6,9; held 10 cycles with start pulses, then ack.
        p = '0; p[2] = 1; p[5] = 1; p[6] = 1; p[9] = 1;
        run_window(32'd4, 32'd0, p, 0, 0, 10, 1);
        // Timeout with start-cycle pulse (not counted); back-to-back start in first IDLE cycle.
        p = '0; p[0] = 1; p[3] = 1; p[4] = 1;
        run_window(32'd10, 32'd7, p, 0, 0, 2, 0);
        // Simultaneous block and time end: block end wins.
        p = '0; p[1] = 1; p[2] = 1; p[5] = 1;
        run_window(32'd3, 32'd5, p, 0, 0, 0, 1);
        // Abort in RUN discards the window.
        p = '1;
        run_window(32'd0, 32'd0, p, 1, 6, 0, 0);

        // Saturation on the 4-bit instance.
        s_start = 1; s_tgt = 0; s_lim = 0; s_bc = 1;
        tick();
        s_start = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("sat_live", 128'({s_lb, s_lc}), 128'({4'((k > 15) ? 15 : k), 4'((k > 15) ? 15 : k)}));
        end
        s_abort = 1; s_bc = 0;
        tick();
        s_abort = 0;
        chk("sat_abort", 128'({s_busy, s_done, s_tout, s_rb, s_rc}), 128'(0));
        tick();
        chk("sat_no_done", 128'(s_done), 128'(0));

        // Reset mid-window at k=4 of a target=8 window.
        start = 1; cfg_tgt = 8; cfg_lim = 0; bc = 0;
        tick();
        start = 0;
        for (int k = 1; k <= 3; k++) begin bc = 1; tick(); end
        bc = 1; rst_n = 0;
        tick();
        rst_n = 1;
        chk("mid_reset", 128'({busy, done, tout, res_blk, res_cyc, live_blk, live_cyc}), 128'(0));
        repeat (3) tick();
        bc = 0;
        chk("post_reset_live", 128'({busy, live_blk}), 128'(0));

        // Randomised windows.
        for (int n = 0; n < 40; n++) begin
            tgt = $urandom_range(0, 6);
            lim = $urandom_range(0, 20);
            p   = {$urandom, $urandom};
            ak  = $urandom_range(1, 15);
            run_window(tgt, lim, p, ($urandom_range(0, 5) == 0), ak,
                       $urandom_range(0, 6), 1'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (3) tick();
        chk("queue_drained", 128'(q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
